// File: rtl/niosii_top_nios2_gen2_0_cpu_debug_moncmd.sv
// Debug monitor command engine: turns JTAG strobes into single-word reads and writes
// on the monitor memory port, with a stall timeout and a sticky error flag.
module niosii_top_nios2_gen2_0_cpu_debug_moncmd #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // state | meaning
  // IDLE  | waiting for a strobe; strobes are accepted only here
  // RD    | read request on the bus until accepted or timed out
  // WR    | write request on the bus until accepted or timed out
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [15:0]       tmo_cnt;
  logic [ADDR_W-1:0] jdo_addr;
  logic              any_strobe;
  logic              acc_a;
  logic              acc_b;
  logic              req_start;
  logic              req_done;
  logic              req_abort;
  logic              set_err;
  logic              clr_err;
  logic              unused_jdo;

  assign jdo_addr   = jdo[17 +: ADDR_W];
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    acc_a      = 1'b0;
    acc_b      = 1'b0;
    req_done   = 1'b0;
    req_abort  = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          acc_a = 1'b1;
          if (jdo[35]) next_state = RD;
        end else if (take_action_ocimem_b) begin
          acc_b      = 1'b1;
          next_state = WR;
        end else if (take_no_action_ocimem_a) begin
          next_state = RD;
        end
      end
      RD, WR: begin
        set_err = any_strobe;
        if (!mem_waitrequest) begin
          req_done   = 1'b1;
          next_state = IDLE;
        end else if (tmo_cnt == T_LAST) begin
          req_abort  = 1'b1;
          set_err    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign req_start = (state == IDLE) && (next_state != IDLE);
  assign clr_err   = acc_a & jdo[36];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      tmo_cnt       <= '0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      mem_read  <= (next_state == RD);
      mem_write <= (next_state == WR);

      if (req_start) begin
        tmo_cnt     <= '0;
        mem_address <= acc_a ? jdo_addr : MonAReg;
      end else if ((state != IDLE) && mem_waitrequest) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (acc_b) mem_writedata <= jdo[34:3];

      if (acc_a) begin
        MonAReg <= jdo_addr;
      end else if (req_done) begin
        MonAReg <= MonAReg + ADDR_ONE;
      end

      if (req_done && (state == RD)) MonDReg <= mem_readdata;

      if (req_start) begin
        monitor_ready <= 1'b0;
      end else if (req_done || req_abort || (acc_a && !jdo[35])) begin
        monitor_ready <= 1'b1;
      end

      // a set in the same cycle as a clear wins
      if (set_err) begin
        monitor_error <= 1'b1;
      end else if (clr_err) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule
